fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage pipeline.
- Keeps a shadow copy of the destination and control fields for the ID/EX, EX/MEM and MEM/WB stages.
- Drives the 2-bit select lines of the two ALU-operand 3:1 forwarding muxes.
- Detects load-use hazards and runs a stall FSM that freezes PC/IF-ID and injects an ID/EX bubble.

---
 rtl/fwd_pkg.sv | 12 +
 rtl/fwd_sel_unit.sv | 22 ++
 rtl/fwd_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared forwarding select codes, stall FSM states and shadow control entry
package fwd_pkg;
  localparam int REG_AW_DEF = 5;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  typedef enum logic {ST_RUN, ST_HOLD} state_t;
  typedef struct packed {
    logic regwrite;
    logic memread;
  } shadow_ctl_t;
endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: priority compare for one ALU operand, EX/MEM beats MEM/WB, $0 never forwarded
module fwd_sel_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_exmem_dest,
  input  logic              i_exmem_rw,
  input  logic [REG_AW-1:0] i_memwb_dest,
  input  logic              i_memwb_rw,
  output logic [1:0]        o_sel
);
  logic w_hit_exmem;
  logic w_hit_memwb;
  // pick the youngest in-flight producer of the source register
  always_comb begin
    w_hit_exmem = i_exmem_rw && (i_exmem_dest != '0) && (i_exmem_dest == i_src);
    w_hit_memwb = i_memwb_rw && (i_memwb_dest != '0) && (i_memwb_dest == i_src);
    o_sel = w_hit_exmem ? FWD_EXMEM : w_hit_memwb ? FWD_MEMWB : FWD_RF;
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding selects and load-use stall control; HAZARD_PERF_CNT_EN adds stall/forward counters
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int STALL_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [REG_AW-1:0] i_id_dest,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_flush,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b,
  output logic              o_pc_write,
  output logic              o_ifid_write,
  output logic              o_idex_bubble,
  output logic              o_stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_count,
  output logic [31:0]       o_fwd_count
`endif
);
  localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

  logic [REG_AW-1:0] r_idex_rs;
  logic [REG_AW-1:0] r_idex_rt;
  logic [REG_AW-1:0] r_idex_dest;
  shadow_ctl_t       r_idex_ctl;
  logic [REG_AW-1:0] r_exmem_dest;
  shadow_ctl_t       r_exmem_ctl;
  logic [REG_AW-1:0] r_memwb_dest;
  logic              r_memwb_rw;
  state_t            r_state;
  logic [2:0]        r_cnt;
  state_t            w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic              w_hazard;
  logic              w_stall;
  logic              w_kill;
  logic              w_unused_exmem_mr;

  assign w_unused_exmem_mr = r_exmem_ctl.memread;
  assign w_kill            = w_stall | i_flush;

  // shadow pipeline: EX/MEM and MEM/WB always advance, ID/EX takes a bubble on stall or flush
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idex_rs    <= '0;
      r_idex_rt    <= '0;
      r_idex_dest  <= '0;
      r_idex_ctl   <= '0;
      r_exmem_dest <= '0;
      r_exmem_ctl  <= '0;
      r_memwb_dest <= '0;
      r_memwb_rw   <= 1'b0;
    end else begin
      r_idex_rs    <= w_kill ? '0 : i_id_rs;
      r_idex_rt    <= w_kill ? '0 : i_id_rt;
      r_idex_dest  <= w_kill ? '0 : i_id_dest;
      r_idex_ctl   <= w_kill ? '0 : '{regwrite: i_id_reg_write, memread: i_id_mem_read};
      r_exmem_dest <= r_idex_dest;
      r_exmem_ctl  <= r_idex_ctl;
      r_memwb_dest <= r_exmem_dest;
      r_memwb_rw   <= r_exmem_ctl.regwrite;
    end
  end

  fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_a (
    .i_src        (r_idex_rs),
    .i_exmem_dest (r_exmem_dest),
    .i_exmem_rw   (r_exmem_ctl.regwrite),
    .i_memwb_dest (r_memwb_dest),
    .i_memwb_rw   (r_memwb_rw),
    .o_sel        (o_forward_a)
  );

  fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_b (
    .i_src        (r_idex_rt),
    .i_exmem_dest (r_exmem_dest),
    .i_exmem_rw   (r_exmem_ctl.regwrite),
    .i_memwb_dest (r_memwb_dest),
    .i_memwb_rw   (r_memwb_rw),
    .o_sel        (o_forward_b)
  );

  // load in EX whose result is needed by the instruction sitting in ID
  always_comb begin
    w_hazard = r_idex_ctl.memread && (r_idex_dest != '0) &&
               ((i_id_uses_rs && (r_idex_dest == i_id_rs)) ||
                (i_id_uses_rt && (r_idex_dest == i_id_rt)));
  end

  // stall FSM state register; HOLD covers the extra bubbles beyond the first
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // stall FSM next state; flush overrides everything and cancels a pending stall
  always_comb begin
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_flush) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_HOLD) begin
      w_stall   = 1'b1;
      w_cnt_nxt = r_cnt - 3'd1;
      if (r_cnt <= 3'd1) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    end else if (w_hazard) begin
      w_stall = 1'b1;
      if (STALL_CYCLES > 1) begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = CNT_INIT;
      end
    end
  end

  assign o_stall       = w_stall;
  assign o_pc_write    = ~w_stall;
  assign o_ifid_write  = ~w_stall;
  assign o_idex_bubble = w_kill;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_fwd_count;
  logic        w_fwd_any;

  assign w_fwd_any     = (o_forward_a != FWD_RF) || (o_forward_b != FWD_RF);
  assign o_stall_count = r_stall_count;
  assign o_fwd_count   = r_fwd_count;

  // saturating event counters for stall cycles and forwarded operands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
      r_fwd_count   <= '0;
    end else begin
      r_stall_count <= (w_stall && (r_stall_count != '1)) ? r_stall_count + 32'd1 : r_stall_count;
      r_fwd_count   <= (w_fwd_any && (r_fwd_count != '1)) ? r_fwd_count + 32'd1 : r_fwd_count;
    end
  end
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed checks of forwarding, load-use stall and flush/reset interaction
module tb_fwd_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_urs, id_urt, id_rw, id_mr, flush;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic       pcw1, ifw1, bub1, st1, pcw3, ifw3, bub3, st3;
  int         errors = 0;
  int         checks = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .STALL_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_urs), .i_id_uses_rt(id_urt), .i_id_dest(id_dest),
    .i_id_reg_write(id_rw), .i_id_mem_read(id_mr), .i_flush(flush),
    .o_forward_a(fa1), .o_forward_b(fb1), .o_pc_write(pcw1), .o_ifid_write(ifw1),
    .o_idex_bubble(bub1), .o_stall(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_count(sc1), .o_fwd_count(fc1)
`endif
  );

  fwd_hazard_ctrl #(.REG_AW(5), .STALL_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_urs), .i_id_uses_rt(id_urt), .i_id_dest(id_dest),
    .i_id_reg_write(id_rw), .i_id_mem_read(id_mr), .i_flush(flush),
    .o_forward_a(fa3), .o_forward_b(fb3), .o_pc_write(pcw3), .o_ifid_write(ifw3),
    .o_idex_bubble(bub3), .o_stall(st3)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_count(sc3), .o_fwd_count(fc3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                    input logic [4:0] dest, input logic rw, input logic mr, input logic fl);
    id_rs = rs; id_rt = rt; id_urs = urs; id_urt = urt;
    id_dest = dest; id_rw = rw; id_mr = mr; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    repeat (n) begin
      id(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_fa", 32'(fa1), 0);
    chk("rst_fb", 32'(fb1), 0);
    chk("rst_stall", 32'(st1), 0);
    chk("rst_pcw", 32'(pcw1), 1);
    chk("rst_ifw", 32'(ifw1), 1);
    chk("rst_bub", 32'(bub1), 0);
    tick();
    rst_n = 1'b1;
    nops(1);
    // add $3,$1,$2 ; sub $4,$3,$5
    id(1, 2, 1, 1, 3, 1, 0, 0);
    tick();
    id(3, 5, 1, 1, 4, 1, 0, 0);
    chk("t1_nostall", 32'(st1), 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_fa_exmem", 32'(fa1), 2);
    chk("t1_fb_rf", 32'(fb1), 0);
    chk("t1_stall", 32'(st1), 0);
    nops(3);
    // add $3 ; nop ; or $6,$7,$3
    id(1, 2, 1, 1, 3, 1, 0, 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    id(7, 3, 1, 1, 6, 1, 0, 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_fb_memwb", 32'(fb1), 1);
    chk("t2_fa_rf", 32'(fa1), 0);
    nops(3);
    // add $3 ; add $3,$1,$1 ; sub $8,$3,$0
    id(1, 2, 1, 1, 3, 1, 0, 0);
    tick();
    id(1, 1, 1, 1, 3, 1, 0, 0);
    tick();
    id(3, 0, 1, 1, 8, 1, 0, 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_fa_prio", 32'(fa1), 2);
    chk("t3_fb_r0", 32'(fb1), 0);
    nops(3);
    // add $0,$1,$2 ; add $5,$0,$0
    id(1, 2, 1, 1, 0, 1, 0, 0);
    tick();
    id(0, 0, 1, 1, 5, 1, 0, 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_fa_r0", 32'(fa1), 0);
    chk("t4_fb_r0", 32'(fb1), 0);
    nops(3);
    // lw $2,0($1) ; add $4,$2,$2
    id(1, 0, 1, 0, 2, 1, 1, 0);
    tick();
    id(2, 2, 1, 1, 4, 1, 0, 0);
    chk("t5_stall", 32'(st1), 1);
    chk("t5_pcw", 32'(pcw1), 0);
    chk("t5_ifw", 32'(ifw1), 0);
    chk("t5_bub", 32'(bub1), 1);
    tick();
    chk("t5_stall_end", 32'(st1), 0);
    chk("t5_pcw_end", 32'(pcw1), 1);
    chk("t5_bub_end", 32'(bub1), 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_fa_memwb", 32'(fa1), 1);
    chk("t5_fb_memwb", 32'(fb1), 1);
    nops(3);
    // lw $2 ; add with flush in the same cycle: flush wins
    id(1, 0, 1, 0, 2, 1, 1, 0);
    tick();
    id(2, 2, 1, 1, 4, 1, 0, 1);
    chk("hf_stall", 32'(st1), 0);
    chk("hf_bub", 32'(bub1), 1);
    chk("hf_pcw", 32'(pcw1), 1);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("hf_killed_fa", 32'(fa1), 0);
    nops(3);
    // lw $2 ; instruction naming $2 but not reading it
    id(1, 0, 1, 0, 2, 1, 1, 0);
    tick();
    id(2, 2, 0, 0, 4, 1, 0, 0);
    chk("nouse_stall", 32'(st1), 0);
    nops(3);
    // lw $0 ; read of $0
    id(1, 0, 1, 0, 0, 1, 1, 0);
    tick();
    id(0, 0, 1, 1, 4, 1, 0, 0);
    chk("lw_r0_stall", 32'(st1), 0);
    nops(3);
    // STALL_CYCLES=3: full three-cycle stall
    id(1, 0, 1, 0, 2, 1, 1, 0);
    tick();
    id(2, 2, 1, 1, 4, 1, 0, 0);
    chk("s3_c1", 32'(st3), 1);
    tick();
    chk("s3_c2", 32'(st3), 1);
    tick();
    chk("s3_c3", 32'(st3), 1);
    chk("s3_c3_pcw", 32'(pcw3), 0);
    tick();
    chk("s3_c4", 32'(st3), 0);
    chk("s3_c4_pcw", 32'(pcw3), 1);
    nops(4);
    // STALL_CYCLES=3: flush in the second stall cycle
    id(1, 0, 1, 0, 2, 1, 1, 0);
    tick();
    id(2, 2, 1, 1, 4, 1, 0, 0);
    chk("s3f_c1", 32'(st3), 1);
    tick();
    id(2, 2, 1, 1, 4, 1, 0, 1);
    chk("s3f_flush_stall", 32'(st3), 0);
    chk("s3f_flush_bub", 32'(bub3), 1);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3f_run_stall", 32'(st3), 0);
    chk("s3f_run_pcw", 32'(pcw3), 1);
    chk("s3f_run_bub", 32'(bub3), 0);
    nops(4);
    // STALL_CYCLES=3: reset mid-HOLD
    id(1, 0, 1, 0, 2, 1, 1, 0);
    tick();
    id(2, 2, 1, 1, 4, 1, 0, 0);
    tick();
    chk("s3r_hold", 32'(st3), 1);
    rst_n = 1'b0;
    #1;
    chk("s3r_stall", 32'(st3), 0);
    chk("s3r_fa", 32'(fa3), 0);
    chk("s3r_fb", 32'(fb3), 0);
    chk("s3r_pcw", 32'(pcw3), 1);
    chk("s3r_bub", 32'(bub3), 0);
    id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    chk("s3r_resume", 32'(st3), 0);
    chk("s3r_resume_ifw", 32'(ifw3), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
